// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg -- shared CPU definitions for the ID/EX pipeline register.
// Holds the default operand/select/control widths, the bit positions inside
// the decoded control bundle, the stage occupancy states and the limit of the
// stall-cycle counter.
package id_ex_stage_pkg;

    localparam int unsigned BREG_DEF  = 32;
    localparam int unsigned BSEL_DEF  = 5;
    localparam int unsigned BCTRL_DEF = 16;

    // Control-bundle bit positions (bundle is bCTRL wide, default 16).
    localparam int unsigned CTRL_REG_WRITE  = 0;
    localparam int unsigned CTRL_MEM_READ   = 1;
    localparam int unsigned CTRL_MEM_WRITE  = 2;
    localparam int unsigned CTRL_MEM_TO_REG = 3;
    localparam int unsigned CTRL_ALU_SRC    = 4;
    localparam int unsigned CTRL_BRANCH     = 5;
    localparam int unsigned CTRL_JUMP       = 6;
    localparam int unsigned CTRL_ALU_OP_LSB = 8;
    localparam int unsigned CTRL_ALU_OP_MSB = 11;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // The encoding doubles as out_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if -- bundle between decode, the ID/EX register and execute.
//   in_*      : instruction fields from decode (in_valid qualifies them)
//   stall     : hold stage content;  flush : kill stage content
//   wb_*      : writeback port, same values driven to the register bank
//   out_*     : registered instruction fields towards execute
//   stall_cycles : saturating count of held valid cycles
// Modports: master = decode/control side, slave = the pipeline register.
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned bREG  = BREG_DEF,
    parameter int unsigned bSEL  = BSEL_DEF,
    parameter int unsigned bCTRL = BCTRL_DEF
) ();

    logic             in_valid;
    logic [bREG-1:0]  in_A, in_B;
    logic [bSEL-1:0]  in_rs, in_rt, in_rd;
    logic [31:0]      in_imm, in_pc;
    logic [bCTRL-1:0] in_ctrl;
    logic             stall, flush;
    logic             wb_en;
    logic [bSEL-1:0]  wb_sel;
    logic [bREG-1:0]  wb_data;

    logic             out_valid;
    logic [bREG-1:0]  out_A, out_B;
    logic [bSEL-1:0]  out_rs, out_rt, out_rd;
    logic [31:0]      out_imm, out_pc;
    logic [bCTRL-1:0] out_ctrl;
    logic [15:0]      stall_cycles;

    modport master (
        output in_valid, in_A, in_B, in_rs, in_rt, in_rd, in_imm, in_pc, in_ctrl,
        output stall, flush, wb_en, wb_sel, wb_data,
        input  out_valid, out_A, out_B, out_rs, out_rt, out_rd, out_imm, out_pc,
        input  out_ctrl, stall_cycles
    );

    modport slave (
        input  in_valid, in_A, in_B, in_rs, in_rt, in_rd, in_imm, in_pc, in_ctrl,
        input  stall, flush, wb_en, wb_sel, wb_data,
        output out_valid, out_A, out_B, out_rs, out_rt, out_rd, out_imm, out_pc,
        output out_ctrl, stall_cycles
    );

endinterface

// File: rtl/id_ex_stage_operand_refresh.sv
// operand_refresh -- writeback forwarding into a held operand.
//   hold_i    : stage is FULL and stalled (not flushed) this edge
//   wb_en_i, wb_sel_i, wb_data_i : writeback port
//   sel_i     : source select latched with the operand
//   val_i     : currently held operand
//   val_o     : operand value to hold for the next cycle
// Register 0 is hard-wired to zero, so a writeback to select 0 never
// refreshes an operand.
module operand_refresh #(
    parameter int unsigned bREG = 32,
    parameter int unsigned bSEL = 5
) (
    input  logic            hold_i,
    input  logic            wb_en_i,
    input  logic [bSEL-1:0] wb_sel_i,
    input  logic [bREG-1:0] wb_data_i,
    input  logic [bSEL-1:0] sel_i,
    input  logic [bREG-1:0] val_i,
    output logic [bREG-1:0] val_o
);

    logic hit;

    always_comb begin
        hit   = hold_i && wb_en_i && (wb_sel_i != '0) && (wb_sel_i == sel_i);
        val_o = hit ? wb_data_i : val_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with stall, flush and writeback
// refresh of held operands.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : id_ex_stage_if.slave (decode inputs, stall/flush, writeback,
//           registered outputs, stall_cycles)
// Priority per edge: flush > capture (no stall) > hold (stall).
// A bubble always carries an all-zero control bundle.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned bREG  = BREG_DEF,
    parameter int unsigned bSEL  = BSEL_DEF,
    parameter int unsigned bCTRL = BCTRL_DEF
) (
    input  logic          clock,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    stage_state_e     state_q, state_d;
    logic [bREG-1:0]  a_q, b_q, a_hold, b_hold;
    logic [bSEL-1:0]  rs_q, rt_q, rd_q;
    logic [31:0]      imm_q, pc_q;
    logic [bCTRL-1:0] ctrl_q;
    logic [15:0]      cnt_q, cnt_d;
    logic             hold_full;

    assign hold_full = (state_q == ST_FULL) && bus.stall && !bus.flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else if (!bus.stall) begin
            state_d = bus.in_valid ? ST_FULL : ST_EMPTY;
        end
        if (hold_full && (cnt_q != STALL_CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    operand_refresh #(.bREG(bREG), .bSEL(bSEL)) u_refresh_a (
        .hold_i    (hold_full),
        .wb_en_i   (bus.wb_en),
        .wb_sel_i  (bus.wb_sel),
        .wb_data_i (bus.wb_data),
        .sel_i     (rs_q),
        .val_i     (a_q),
        .val_o     (a_hold)
    );

    operand_refresh #(.bREG(bREG), .bSEL(bSEL)) u_refresh_b (
        .hold_i    (hold_full),
        .wb_en_i   (bus.wb_en),
        .wb_sel_i  (bus.wb_sel),
        .wb_data_i (bus.wb_data),
        .sel_i     (rt_q),
        .val_i     (b_q),
        .val_o     (b_hold)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
            imm_q  <= '0;
            pc_q   <= '0;
            ctrl_q <= '0;
        end else if (bus.flush) begin
            ctrl_q <= '0;
        end else if (!bus.stall) begin
            a_q    <= bus.in_A;
            b_q    <= bus.in_B;
            rs_q   <= bus.in_rs;
            rt_q   <= bus.in_rt;
            rd_q   <= bus.in_rd;
            imm_q  <= bus.in_imm;
            pc_q   <= bus.in_pc;
            ctrl_q <= bus.in_valid ? bus.in_ctrl : '0;
        end else begin
            // Refresh only acts when FULL (hold_full); otherwise passes through.
            a_q <= a_hold;
            b_q <= b_hold;
        end
    end

    assign bus.out_valid    = (state_q == ST_FULL);
    assign bus.out_A        = a_q;
    assign bus.out_B        = b_q;
    assign bus.out_rs       = rs_q;
    assign bus.out_rt       = rt_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_imm      = imm_q;
    assign bus.out_pc       = pc_q;
    assign bus.out_ctrl     = ctrl_q;
    assign bus.stall_cycles = cnt_q;

endmodule
